// File: rtl/regfile_writeback.sv
// Register file write-back front end: merges ALU and load results into a FIFO,
// drops x0 writes and drives one register file write per cycle. Option: WB_SCOREBOARD_EN.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_rd,
    input  logic [31:0]              ld_data,
    output logic                     ld_ready,
    output logic                     writeenable,
    output logic [4:0]               rd,
    output logic [31:0]              datain,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [4:0]               query_rs1,
    input  logic [4:0]               query_rs2,
    output logic                     rs1_pending,
    output logic                     rs2_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] alu_idx;
    logic [CW-1:0] count_q, count_d;
    logic          we_q;
    logic [4:0]    rd_q;
    logic [31:0]   data_q;
    logic          ld_push, alu_push, pop;

    // Readiness looks only at registered occupancy so producers never see
    // a combinational path through valid or through this cycle's pop.
    assign ld_ready  = (count_q < CW'(DEPTH));
    assign alu_ready = (count_q <= CW'(DEPTH - 2));

    assign writeenable = we_q;
    assign rd          = rd_q;
    assign datain      = data_q;
    assign count       = count_q;

    // Push/pop decisions and pointer arithmetic; load is older than ALU
    always_comb begin
        ld_push  = ld_valid && ld_ready && (ld_rd != 5'd0);
        alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
        pop      = (count_q != '0);
        alu_idx  = wr_ptr_q + PW'(ld_push);
        wr_ptr_d = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end

    // FIFO storage, pointers, occupancy and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            if (ld_push) begin
                rd_mem_q[wr_ptr_q]   <= ld_rd;
                data_mem_q[wr_ptr_q] <= ld_data;
            end
            if (alu_push) begin
                rd_mem_q[alu_idx]   <= alu_rd;
                data_mem_q[alu_idx] <= alu_data;
            end
            if (pop) begin
                we_q   <= 1'b1;
                rd_q   <= rd_mem_q[rd_ptr_q];
                data_q <= data_mem_q[rd_ptr_q];
            end else begin
                we_q <= 1'b0;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [DEPTH-1:0] vld_q;
    logic             rs1_hit, rs2_hit;

    // Per-entry valid bits; a slot is never pushed and popped on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            if (pop)      vld_q[rd_ptr_q] <= 1'b0;
            if (ld_push)  vld_q[wr_ptr_q] <= 1'b1;
            if (alu_push) vld_q[alu_idx]  <= 1'b1;
        end
    end

    // A source is pending while queued or sitting in the output register
    always_comb begin
        rs1_hit = we_q && (rd_q == query_rs1);
        rs2_hit = we_q && (rd_q == query_rs2);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_mem_q[i] == query_rs1)) rs1_hit = 1'b1;
            if (vld_q[i] && (rd_mem_q[i] == query_rs2)) rs2_hit = 1'b1;
        end
        rs1_pending = rs1_hit && (query_rs1 != 5'd0);
        rs2_pending = rs2_hit && (query_rs2 != 5'd0);
    end
`else
    logic unused_query;

    assign unused_query = ^{query_rs1, query_rs2};
    assign rs1_pending  = 1'b0;
    assign rs2_pending  = 1'b0;
`endif

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) count_q <= CW'(DEPTH)
    ) else $error("regfile_writeback: FIFO occupancy above DEPTH");
`endif

endmodule
